gsensor_hex_display: RTL and testbench

GSENSOR_HEX_DISPLAY -- requirements
Module: gsensor_hex_display

---
 rtl/gsensor_pkg.sv | 51 +++++
 rtl/gsensor_axis_decode.sv | 33 +++
 rtl/gsensor_hex_display.sv | 138 +++++++++++++
 tb/tb_gsensor_hex_display.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_pkg.sv
// ============================================================================
// gsensor_pkg : shared glyph patterns, axis codes and digit helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package gsensor_pkg;

    typedef logic [6:0] seg7_t;

    // Active-low {g,f,e,d,c,b,a} glyphs
    localparam seg7_t C_SEG_0     = 7'b1000000;
    localparam seg7_t C_SEG_1     = 7'b1111001;
    localparam seg7_t C_SEG_2     = 7'b0100100;
    localparam seg7_t C_SEG_3     = 7'b0110000;
    localparam seg7_t C_SEG_DASH  = 7'b0111111;
    localparam seg7_t C_SEG_E     = 7'b0000110;
    localparam seg7_t C_SEG_BLANK = 7'b1111111;

    localparam logic [7:0] C_AXIS_LEVEL = 8'h00;
    localparam logic [7:0] C_AXIS_POS1  = 8'hA1;
    localparam logic [7:0] C_AXIS_POS2  = 8'hA2;
    localparam logic [7:0] C_AXIS_POS3  = 8'hA3;
    localparam logic [7:0] C_AXIS_NEG1  = 8'hB1;
    localparam logic [7:0] C_AXIS_NEG2  = 8'hB2;
    localparam logic [7:0] C_AXIS_NEG3  = 8'hB3;

    localparam logic [15:0] C_CODE_LEVEL = 16'h0000;

    typedef enum logic [1:0] {
        DIG_Y_MAG  = 2'd0,
        DIG_Y_SIGN = 2'd1,
        DIG_X_MAG  = 2'd2,
        DIG_X_SIGN = 2'd3
    } digit_t;

    function automatic logic [3:0] digit_enable(input digit_t idx);
        logic [3:0] en;
        case (idx)
            DIG_Y_MAG:  en = 4'b1110;
            DIG_Y_SIGN: en = 4'b1101;
            DIG_X_MAG:  en = 4'b1011;
            DIG_X_SIGN: en = 4'b0111;
            default:    en = 4'b1111;
        endcase
        return en;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gsensor_axis_decode.sv
// ============================================================================
// gsensor_axis_decode : one tilt-axis byte to sign and magnitude glyphs
// Rev 1.0
// ============================================================================
`default_nettype none

module gsensor_axis_decode (
    input  logic [7:0] axis_i,
    output logic [6:0] sign_o,
    output logic [6:0] mag_o
);

    import gsensor_pkg::*;

    always_comb begin
        // Anything outside the known code set shows as "-E"
        sign_o = C_SEG_DASH;
        mag_o  = C_SEG_E;
        case (axis_i)
            C_AXIS_LEVEL: begin sign_o = C_SEG_BLANK; mag_o = C_SEG_0; end
            C_AXIS_POS1:  begin sign_o = C_SEG_BLANK; mag_o = C_SEG_1; end
            C_AXIS_POS2:  begin sign_o = C_SEG_BLANK; mag_o = C_SEG_2; end
            C_AXIS_POS3:  begin sign_o = C_SEG_BLANK; mag_o = C_SEG_3; end
            C_AXIS_NEG1:  begin sign_o = C_SEG_DASH;  mag_o = C_SEG_1; end
            C_AXIS_NEG2:  begin sign_o = C_SEG_DASH;  mag_o = C_SEG_2; end
            C_AXIS_NEG3:  begin sign_o = C_SEG_DASH;  mag_o = C_SEG_3; end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gsensor_hex_display.sv
// ============================================================================
// gsensor_hex_display : debounced tilt code shown on a 4-digit multiplexed
//                       7-segment display with a blinking level indicator
// Rev 1.0
// ============================================================================
`default_nettype none

module gsensor_hex_display #(
    parameter int SCAN_DIV      = 50000,
    parameter int STABLE_CYCLES = 1000000,
    parameter int BLINK_DIV     = 12500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] gsensor_hex_data,
    output logic [7:0]  seg,
    output logic [3:0]  dig_en,
    output logic        level_ok,
    output logic        disp_update
);

    import gsensor_pkg::*;

    localparam int C_SCAN_W  = (SCAN_DIV > 1)      ? $clog2(SCAN_DIV)      : 1;
    localparam int C_STAB_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int C_BLINK_W = (BLINK_DIV > 1)     ? $clog2(BLINK_DIV)     : 1;

    localparam logic [C_SCAN_W-1:0]  C_SCAN_LAST  = C_SCAN_W'(SCAN_DIV - 1);
    localparam logic [C_STAB_W-1:0]  C_STAB_LAST  = C_STAB_W'(STABLE_CYCLES - 1);
    localparam logic [C_STAB_W-1:0]  C_STAB_PRE   = C_STAB_W'(STABLE_CYCLES - 2);
    localparam logic [C_BLINK_W-1:0] C_BLINK_LAST = C_BLINK_W'(BLINK_DIV - 1);

    logic [15:0]          cand_q;
    logic [C_STAB_W-1:0]  stab_cnt_q;
    logic [15:0]          disp_q;
    logic                 level_q;
    logic                 upd_q;

    logic [C_SCAN_W-1:0]  scan_cnt_q;
    digit_t               idx_q;
    logic [C_BLINK_W-1:0] blink_cnt_q;
    logic                 phase_q;
    logic [7:0]           seg_q;
    logic [3:0]           dig_en_q;

    logic [7:0]           seg_d;
    logic [3:0]           dig_en_d;

    logic [6:0]           sign_seg [2];
    logic [6:0]           mag_seg  [2];

    // Index 1 decodes the X byte, index 0 the Y byte
    for (genvar a = 0; a < 2; a++) begin : g_axis
        gsensor_axis_decode u_axis_decode (
            .axis_i (disp_q[a*8 +: 8]),
            .sign_o (sign_seg[a]),
            .mag_o  (mag_seg[a])
        );
    end

    // Any input change restarts the stability window from zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q     <= C_CODE_LEVEL;
            stab_cnt_q <= '0;
            disp_q     <= C_CODE_LEVEL;
            level_q    <= 1'b1;
            upd_q      <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (gsensor_hex_data != cand_q) begin
                cand_q     <= gsensor_hex_data;
                stab_cnt_q <= '0;
            end else if (stab_cnt_q != C_STAB_LAST) begin
                stab_cnt_q <= stab_cnt_q + 1'b1;
                if ((stab_cnt_q == C_STAB_PRE) && (cand_q != disp_q)) begin
                    disp_q  <= cand_q;
                    level_q <= (cand_q == C_CODE_LEVEL);
                    upd_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        seg_d = 8'hFF;
        case (idx_q)
            DIG_X_SIGN: seg_d[6:0] = sign_seg[1];
            DIG_X_MAG:  seg_d[6:0] = mag_seg[1];
            DIG_Y_SIGN: seg_d[6:0] = sign_seg[0];
            DIG_Y_MAG:  seg_d[6:0] = mag_seg[0];
            default:    seg_d[6:0] = C_SEG_BLANK;
        endcase
        // level_q gating keeps dp dark on the very edge the code leaves level
        seg_d[7] = ~(level_q && phase_q &&
                     ((idx_q == DIG_X_MAG) || (idx_q == DIG_Y_MAG)));
        dig_en_d = digit_enable(idx_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= DIG_Y_MAG;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= 8'hFF;
            dig_en_q    <= 4'hF;
        end else begin
            if (scan_cnt_q == C_SCAN_LAST) begin
                scan_cnt_q <= '0;
                idx_q      <= digit_t'(idx_q + 2'd1);
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end

            if (!level_q) begin
                blink_cnt_q <= '0;
                phase_q     <= 1'b0;
            end else if (blink_cnt_q == C_BLINK_LAST) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end

            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
        end
    end

    assign seg         = seg_q;
    assign dig_en      = dig_en_q;
    assign level_ok    = level_q;
    assign disp_update = upd_q;

endmodule

`default_nettype wire

// File: tb/tb_gsensor_hex_display.sv
// ============================================================================
// tb_gsensor_hex_display : scoreboard bench for gsensor_hex_display
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gsensor_hex_display;

    localparam int SCAN_DIV      = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int BLINK_DIV     = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [7:0]  seg;
    logic [3:0]  dig_en;
    logic        level_ok;
    logic        disp_update;

    gsensor_hex_display #(
        .SCAN_DIV      (SCAN_DIV),
        .STABLE_CYCLES (STABLE_CYCLES),
        .BLINK_DIV     (BLINK_DIV)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .gsensor_hex_data (data),
        .seg              (seg),
        .dig_en           (dig_en),
        .level_ok         (level_ok),
        .disp_update      (disp_update)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        bit         wait_dig;
        logic [3:0] dig;
        logic [3:0] dmask;
        logic [7:0] seg;
        logic [7:0] smask;
        logic       lvl;
        logic       upd;
    } exp_t;

    typedef struct {
        string name;
        int    cyc;
        logic  lvl;
    } upd_t;

    exp_t exp_q[$];
    upd_t upd_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push_strict(string n, logic [3:0] d, logic [7:0] s, logic l);
        exp_t e;
        e.name = n; e.wait_dig = 1'b0; e.dig = d; e.dmask = 4'hF;
        e.seg = s; e.smask = 8'hFF; e.lvl = l; e.upd = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_digit(string n, logic [3:0] d, logic [7:0] s, logic l);
        exp_t e;
        e.name = n; e.wait_dig = 1'b1; e.dig = d; e.dmask = 4'hF;
        e.seg = s; e.smask = 8'hFF; e.lvl = l; e.upd = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_dp_high(string n, logic l);
        exp_t e;
        e.name = n; e.wait_dig = 1'b0; e.dig = 4'h0; e.dmask = 4'h0;
        e.seg = 8'h80; e.smask = 8'h80; e.lvl = l; e.upd = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_upd(string n, int c, logic l);
        upd_t u;
        u.name = n; u.cyc = c; u.lvl = l;
        upd_q.push_back(u);
    endfunction

    // Monitor: pops expectations as the DUT presents outputs
    exp_t e_m;
    upd_t u_m;
    always @(negedge clk) begin
        if (disp_update === 1'b1) begin
            checks++;
            if (upd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update cyc=%0d got disp_update=1 need 0", cyc);
            end else begin
                u_m = upd_q.pop_front();
                if (cyc != u_m.cyc || level_ok !== u_m.lvl) begin
                    errors++;
                    $display("FAIL %s got cyc=%0d level_ok=%b need cyc=%0d level_ok=%b",
                             u_m.name, cyc, level_ok, u_m.cyc, u_m.lvl);
                end
            end
        end
        if (exp_q.size() > 0) begin
            if (!exp_q[0].wait_dig || dig_en === exp_q[0].dig) begin
                e_m = exp_q.pop_front();
                checks++;
                if (((dig_en & e_m.dmask) !== (e_m.dig & e_m.dmask)) ||
                    ((seg & e_m.smask) !== (e_m.seg & e_m.smask)) ||
                    (level_ok !== e_m.lvl) || (disp_update !== e_m.upd)) begin
                    errors++;
                    $display("FAIL %s got dig_en=%b seg=%h level_ok=%b upd=%b need dig_en=%b seg=%h (mask %h) level_ok=%b upd=%b",
                             e_m.name, dig_en, seg, level_ok, disp_update,
                             e_m.dig, e_m.seg, e_m.smask, e_m.lvl, e_m.upd);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while ((exp_q.size() > 0 || upd_q.size() > 0) && b > 0) begin
            @(negedge clk);
            #1;
            b--;
        end
        checks++;
        if (exp_q.size() > 0 || upd_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d/%0d need 0/0", exp_q.size(), upd_q.size());
            exp_q.delete();
            upd_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] one;
        logic [3:0] dg;
        logic [6:0] gl;
        logic       dp;
        int         idx;

        // Reset values while held low
        reset_n = 1'b0;
        data    = 16'h0000;
        tick(3);
        push_strict("reset_hold", 4'hF, 8'hFF, 1'b1);
        drain(4);

        // Level code from reset: scan order plus dp blink over 40 clocks
        reset_n = 1'b1;
        one = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            idx = (c / 4) % 4;
            dg  = ~(one << idx);
            gl  = (idx % 2 == 0) ? 7'b1000000 : 7'b1111111;
            dp  = !(((c / 16) % 2 == 1) && (idx % 2 == 0));
            push_strict("level_scan", dg, {dp, gl}, 1'b1);
        end
        drain(50);

        // B2A3 held: one update after 8 clocks, shows "-2 3"
        data = 16'hB2A3;
        push_upd("b2a3_update", cyc + 8, 1'b0);
        drain(20);
        push_digit("b2a3_d0", 4'b1110, 8'hB0, 1'b0);
        push_digit("b2a3_d1", 4'b1101, 8'hFF, 1'b0);
        push_digit("b2a3_d2", 4'b1011, 8'hA4, 1'b0);
        push_digit("b2a3_d3", 4'b0111, 8'hBF, 1'b0);
        drain(40);

        // Toggling every 5 clocks never settles
        for (int k = 0; k < 8; k++) begin
            data = (k % 2 == 0) ? 16'hA1A1 : 16'h0000;
            tick(5);
        end
        data = 16'hB2A3;
        tick(12);
        push_digit("toggle_d0", 4'b1110, 8'hB0, 1'b0);
        push_digit("toggle_d1", 4'b1101, 8'hFF, 1'b0);
        push_digit("toggle_d2", 4'b1011, 8'hA4, 1'b0);
        push_digit("toggle_d3", 4'b0111, 8'hBF, 1'b0);
        drain(40);

        // Invalid Y byte shows "-E"
        data = 16'h00FF;
        push_upd("00ff_update", cyc + 8, 1'b0);
        drain(20);
        push_digit("00ff_d0", 4'b1110, 8'h86, 1'b0);
        push_digit("00ff_d1", 4'b1101, 8'hBF, 1'b0);
        push_digit("00ff_d2", 4'b1011, 8'hC0, 1'b0);
        push_digit("00ff_d3", 4'b0111, 8'hFF, 1'b0);
        drain(40);

        // Back to level, let phase go high, then leave level: dp forced high
        data = 16'h0000;
        push_upd("level_update", cyc + 8, 1'b1);
        drain(20);
        tick(20);
        data = 16'hA1A1;
        push_upd("a1a1_update", cyc + 8, 1'b0);
        drain(20);
        for (int k = 0; k < 8; k++) push_dp_high("nonlevel_dp", 1'b0);
        drain(12);

        // Reset pulsed mid-filter at count 5
        data = 16'hA2A2;
        tick(6);
        #2;
        reset_n = 1'b0;
        push_strict("reset_async", 4'hF, 8'hFF, 1'b1);
        data = 16'h0000;
        drain(2);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) push_strict("post_reset_d0", 4'b1110, 8'hC0, 1'b1);
        push_strict("post_reset_d1", 4'b1101, 8'hFF, 1'b1);
        drain(8);
        tick(20);
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
